// File: rtl/ratio_width_fifo.sv
// ratio_width_fifo
// Synchronous FIFO whose write and read ports have different widths related
// by an integer ratio. Storage is kept in G-bit units, G = min(W_IN, W_OUT).
// A push writes UI = W_IN/G units and a pop removes UO = W_OUT/G units.
// Slices are little-endian: the least-significant slice occupies the lowest
// address. Read data falls through combinationally from the read pointer.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   push         write request, accepted when !full
//   pop          read request, accepted when !empty
//   d            write data, W_IN bits
//   q            read data, W_OUT bits, valid whenever empty==0 (0 while empty)
//   full         fewer than UI free units
//   empty        fewer than UO stored units
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        stored units, $clog2(DEPTH)+1 bits
//
// Optional build macro RATIO_WIDTH_FIFO_ERR_EN adds sticky outputs:
//   overflow     set by push while full, cleared only by reset
//   underflow    set by pop while empty, cleared only by reset
//
// Handshake: a request is accepted on a rising edge when it is high and the
// matching registered guard (full for push, empty for pop) is low at that
// edge; rejected requests change no state.
module ratio_width_fifo #(
  parameter int W_IN     = 8,
  parameter int W_OUT    = 4,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = DEPTH - 16,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W_IN-1:0]            d,
  output logic [W_OUT-1:0]           q,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef RATIO_WIDTH_FIFO_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int G  = (W_IN < W_OUT) ? W_IN : W_OUT;
  localparam int UI = W_IN / G;
  localparam int UO = W_OUT / G;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [G-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          push_ok, pop_ok;
  logic [W_OUT-1:0] rd_word;

  // Guards use pre-edge flags only, so a same-cycle pop never makes room
  // for a push and a same-cycle push never makes data available to a pop.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(UI);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(UO);
    end
    // Unsigned wrap in the intermediate sum is harmless: a pop is only
    // accepted when at least UO units are stored.
    count_d = count_q + (push_ok ? CW'(UI) : '0) - (pop_ok ? CW'(UO) : '0);
    // Flags are computed from the next count so they update on the same
    // edge as the pointers.
    full_d  = (CW'(DEPTH) - count_d) < CW'(UI);
    empty_d = count_d < CW'(UO);
    af_d    = count_d >= CW'(AF_LEVEL);
    ae_d    = count_d <= CW'(AE_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int k = 0; k < UI; k++) begin
        mem_q[wr_ptr_q + PW'(k)] <= d[G*k +: G];
      end
    end
  end

  for (genvar k = 0; k < UO; k++) begin : g_rd
    assign rd_word[G*k +: G] = mem_q[rd_ptr_q + PW'(k)];
  end

  // Forcing q to zero while empty gives a defined reset value and keeps q
  // steady across ignored pops.
  assign q            = empty_q ? '0 : rd_word;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef RATIO_WIDTH_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (push & full_q);
      udf_q <= udf_q | (pop & empty_q);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_ratio_width_fifo.sv
// Bench for ratio_width_fifo: an 8->4, DEPTH=128 instance (a) and a
// 4->16, DEPTH=64 instance (b), sharing clock and reset.
module tb_ratio_width_fifo;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // instance a: 8 -> 4, DEPTH 128
  logic       push_a, pop_a;
  logic [7:0] d_a;
  logic [3:0] q_a;
  logic       full_a, empty_a, af_a, ae_a;
  logic [7:0] count_a;

  // instance b: 4 -> 16, DEPTH 64
  logic        push_b, pop_b;
  logic [3:0]  d_b;
  logic [15:0] q_b;
  logic        full_b, empty_b, af_b, ae_b;
  logic [6:0]  count_b;

`ifdef RATIO_WIDTH_FIFO_ERR_EN
  logic ovf_a, udf_a, ovf_b, udf_b;
`endif

  ratio_width_fifo #(.W_IN(8), .W_OUT(4), .DEPTH(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .d(d_a), .q(q_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(count_a)
`ifdef RATIO_WIDTH_FIFO_ERR_EN
    , .overflow(ovf_a), .underflow(udf_a)
`endif
  );

  ratio_width_fifo #(.W_IN(4), .W_OUT(16), .DEPTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .d(d_b), .q(q_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b)
`ifdef RATIO_WIDTH_FIFO_ERR_EN
    , .overflow(ovf_b), .underflow(udf_b)
`endif
  );

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance a; the reference queue follows the acceptance
  // rules using its own occupancy.
  task automatic a_cycle(input logic p, input logic r, input logic [7:0] v);
    logic acc_p, acc_r;
    acc_p = p && ((128 - exp_q.size()) >= 2);
    acc_r = r && (exp_q.size() >= 1);
    push_a = p;
    pop_a  = r;
    d_a    = v;
    tick();
    push_a = 1'b0;
    pop_a  = 1'b0;
    if (acc_r) void'(exp_q.pop_front());
    if (acc_p) begin
      exp_q.push_back(v[3:0]);
      exp_q.push_back(v[7:4]);
    end
  endtask

  task automatic b_push(input logic [3:0] v);
    push_b = 1'b1;
    d_b    = v;
    tick();
    push_b = 1'b0;
  endtask

  initial begin
    logic [3:0] nib_b [4];
    logic p, r;
    int guard;

    rst_n  = 1'b0;
    push_a = 1'b0; pop_a = 1'b0; d_a = '0;
    push_b = 1'b0; pop_b = 1'b0; d_b = '0;

    // reset / idle
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ae", ae_a, 1);
    chk("rst_af", af_a, 0);
    chk("rst_q", q_a, 0);
    chk("rst_b_empty", empty_b, 1);
    chk("rst_b_count", count_b, 0);

    // narrow-to-wide: 0xA,0xB,0xC stay unreadable, 0xD completes 0xDCBA
    nib_b[0] = 4'hA; nib_b[1] = 4'hB; nib_b[2] = 4'hC; nib_b[3] = 4'hD;
    for (int i = 0; i < 3; i++) begin
      b_push(nib_b[i]);
      chk("n2w_partial_empty", empty_b, 1);
      chk("n2w_partial_count", count_b, i + 1);
    end
    b_push(nib_b[3]);
    chk("n2w_empty", empty_b, 0);
    chk("n2w_count", count_b, 4);
    chk("n2w_q", q_b, 16'hDCBA);
    chk("n2w_ae", ae_b, 1);
    pop_b = 1'b1;
    tick();
    pop_b = 1'b0;
    chk("n2w_pop_count", count_b, 0);
    chk("n2w_pop_empty", empty_b, 1);

    // fill wide-to-narrow with bytes 1..64
    for (int i = 1; i <= 64; i++) begin
      a_cycle(1'b1, 1'b0, 8'(i));
      chk("fill_count", count_a, 2 * i);
      chk("fill_af", af_a, (2 * i >= 112) ? 1 : 0);
      chk("fill_full", full_a, (2 * i >= 127) ? 1 : 0);
      chk("fill_ae", ae_a, (2 * i <= 4) ? 1 : 0);
    end
    a_cycle(1'b1, 1'b0, 8'hFF);
    chk("push_full_count", count_a, 128);
    chk("push_full_full", full_a, 1);
`ifdef RATIO_WIDTH_FIFO_ERR_EN
    chk("overflow_set", ovf_a, 1);
`endif

    // drain in order: i%16 then i/16
    for (int i = 1; i <= 64; i++) begin
      chk("drain_lo", q_a, i % 16);
      chk("drain_model_lo", exp_q[0], i % 16);
      a_cycle(1'b0, 1'b1, 8'h00);
      chk("drain_hi", q_a, i / 16);
      a_cycle(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", empty_a, 1);
    chk("drain_count", count_a, 0);
    a_cycle(1'b0, 1'b1, 8'h00);
    chk("pop_empty_count", count_a, 0);
    chk("pop_empty_q", q_a, 0);
`ifdef RATIO_WIDTH_FIFO_ERR_EN
    chk("overflow_sticky", ovf_a, 1);
    chk("underflow_set", udf_a, 1);
`endif

    // simultaneous push/pop at count 64
    for (int i = 0; i < 32; i++) a_cycle(1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_sim_count", count_a, 64);
    a_cycle(1'b1, 1'b1, 8'h5A);
    chk("sim_count", count_a, 65);

    // 300 mixed cycles: fill-leaning phase, then drain-leaning phase
    for (int c = 0; c < 300; c++) begin
      if (c < 150) begin
        p = (c % 3) != 2;
        r = (c % 4) != 0;
      end else begin
        p = (c % 3) == 0;
        r = 1'b1;
      end
      a_cycle(p, r, 8'((c * 37 + 11) % 256));
      chk("mix_count", count_a, exp_q.size());
      chk("mix_full", full_a, ((128 - exp_q.size()) < 2) ? 1 : 0);
      chk("mix_empty", empty_a, (exp_q.size() == 0) ? 1 : 0);
      if (exp_q.size() > 0) chk("mix_q", q_a, exp_q[0]);
    end

    // drain what is left, then build count 40
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      chk("tail_q", q_a, exp_q[0]);
      a_cycle(1'b0, 1'b1, 8'h00);
      guard++;
    end
    chk("tail_empty", empty_a, 1);
    for (int i = 0; i < 20; i++) a_cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("pre_rst_count", count_a, 40);

    // asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk("async_count", count_a, 0);
    chk("async_empty", empty_a, 1);
    chk("async_ae", ae_a, 1);
`ifdef RATIO_WIDTH_FIFO_ERR_EN
    chk("async_ovf_clr", ovf_a, 0);
    chk("async_udf_clr", udf_a, 0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_count", count_a, 0);
    chk("post_rst_q", q_a, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
